// File: rtl/cpu_flags_pkg.sv
// Shared flag-unit types: ALU flag-update classes and the {Z,N,V} flag word.
package cpu_flags_pkg;

  typedef enum logic [1:0] {
    FLAG_ADD    = 2'b00,
    FLAG_SUB    = 2'b01,
    FLAG_LOGIC  = 2'b10,
    FLAG_NOFLAG = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/flag_stack.sv
// LIFO shadow stack for the flag word: storage, occupancy count and sticky
// overflow/underflow bits. A simultaneous push and pop is a no-op.
module flag_stack
  import cpu_flags_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clr_err_i,
  input  flags_t                   wdata_i,
  output flags_t                   rdata_o,
  output logic                     pop_ok_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  flags_t          mem_q [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            full, empty, push_only, pop_only, do_push, do_pop;
  logic [AW-1:0]   top_idx;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign push_only = push_i & ~pop_i;
  assign pop_only  = pop_i & ~push_i;
  assign do_push   = push_only & ~full;
  assign do_pop    = pop_only & ~empty;
  // Top entry sits one below the write pointer; wraps to DEPTH-1 when full.
  assign top_idx   = count_q[AW-1:0] - AW'(1);

  // Next count and sticky errors; a new error wins over a same-cycle clear.
  always_comb begin
    count_d = count_q;
    if (do_push)     count_d = count_q + CW'(1);
    else if (do_pop) count_d = count_q - CW'(1);
    ovf_d = (ovf_q & ~clr_err_i) | (push_only & full);
    unf_d = (unf_q & ~clr_err_i) | (pop_only & empty);
  end

  // Count and error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage; contents are never read before being written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[count_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o     = mem_q[top_idx];
  assign pop_ok_o    = do_pop;
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: rtl/status_flag_unit.sv
// Architectural Z/N/V flag registers fed by the ALU result, with a shadow
// stack that saves and restores them across interrupt entry and return.
module status_flag_unit
  import cpu_flags_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           iClk,
  input  logic                           iRst_n,
  input  logic                           iAluValid,
  input  logic [1:0]                     iAluOp,
  input  logic [DATA_WIDTH-1:0]          iOperandA,
  input  logic [DATA_WIDTH-1:0]          iOperandB,
  input  logic [DATA_WIDTH-1:0]          iResult,
  input  logic                           iFlush,
  input  logic                           iPush,
  input  logic                           iPop,
  input  logic                           iClearErr,
  output logic                           oZeroFlag,
  output logic                           oNegativeFlag,
  output logic                           oOverflowFlag,
  output logic [$clog2(STACK_DEPTH):0]   oStackCount,
  output logic                           oStackOverflow,
  output logic                           oStackUnderflow
);

  localparam int MSB = DATA_WIDTH - 1;

  flags_t flags_q, flags_d, alu_flags, top_entry;
  logic   upd, restore;
  logic   a_s, b_s, r_s;

  assign a_s = iOperandA[MSB];
  assign b_s = iOperandB[MSB];
  assign r_s = iResult[MSB];
  assign upd = iAluValid & ~iFlush & (alu_op_e'(iAluOp) != FLAG_NOFLAG);

  // Flags implied by this cycle's ALU result.
  always_comb begin
    alu_flags.z = (iResult == '0);
    alu_flags.n = r_s;
    case (alu_op_e'(iAluOp))
      FLAG_ADD: alu_flags.v = (a_s == b_s) & (r_s != a_s);
      FLAG_SUB: alu_flags.v = (a_s != b_s) & (r_s != a_s);
      default:  alu_flags.v = 1'b0;
    endcase
  end

  // The stack saves the pre-edge flags, so a push never sees this cycle's update.
  flag_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk_i       (iClk),
    .rst_ni      (iRst_n),
    .push_i      (iPush),
    .pop_i       (iPop),
    .clr_err_i   (iClearErr),
    .wdata_i     (flags_q),
    .rdata_o     (top_entry),
    .pop_ok_o    (restore),
    .count_o     (oStackCount),
    .overflow_o  (oStackOverflow),
    .underflow_o (oStackUnderflow)
  );

  // A successful restore overrides any ALU update in the same cycle.
  always_comb begin
    flags_d = flags_q;
    if (restore)  flags_d = top_entry;
    else if (upd) flags_d = alu_flags;
  end

  // Architectural flag registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) flags_q <= '0;
    else         flags_q <= flags_d;
  end

  assign oZeroFlag     = flags_q.z;
  assign oNegativeFlag = flags_q.n;
  assign oOverflowFlag = flags_q.v;

endmodule

// File: doc/status_flag_unit.md
# status_flag_unit

Status-flag producer for the processor datapath. It derives Zero, Negative and Overflow from each ALU result and holds them in architectural flag registers. A small LIFO shadow stack saves and restores the flags across interrupt entry and return. The registered flag outputs drive the branch-decision logic's iZeroFlag, iNegativeFlag and iOverflowFlag inputs.

## Interface
- DATA_WIDTH, 16: ALU operand and result width, at least 2.
- STACK_DEPTH, 4: shadow-stack entries, a power of two, at least 2.

- iClk, input, 1: clock. All state changes on its rising edge.
- iRst_n, input, 1: reset. Asynchronous assert, active-low. Synchronous to iClk on deassertion.
- iAluValid, input, 1: the ALU result this cycle is a committing instruction.
- iAluOp, input, 2: flag-update class. 00 ADD, 01 SUB, 10 LOGIC, 11 NOFLAG.
- iOperandA, input, DATA_WIDTH: ALU operand A.
- iOperandB, input, DATA_WIDTH: ALU operand B. For SUB, the ALU computes A−B.
- iResult, input, DATA_WIDTH: ALU result.
- iFlush, input, 1: squash this cycle's ALU update.
- iPush, input, 1: save the current flags (interrupt entry).
- iPop, input, 1: restore flags from the stack (interrupt return).
- iClearErr, input, 1: clear the sticky error bits.
- oZeroFlag, output, 1: Z register.
- oNegativeFlag, output, 1: N register.
- oOverflowFlag, output, 1: V register.
- oStackCount, output, $clog2(STACK_DEPTH)+1: number of occupied stack entries.
- oStackOverflow, output, 1: sticky. Set when a push arrives while the stack is full.
- oStackUnderflow, output, 1: sticky. Set when a pop arrives while the stack is empty.

## Operation
- Update enable: upd = iAluValid & ~iFlush & (iAluOp != NOFLAG).
- Z = (iResult == 0). N = iResult[MSB].
- ADD: V = (A[MSB] == B[MSB]) & (R[MSB] != A[MSB]).
- SUB: V = (A[MSB] != B[MSB]) & (R[MSB] != A[MSB]).
- LOGIC: V = 0. Z and N are computed as above.
- Stack entry format: a 3-bit word {Z, N, V}. The write pointer equals oStackCount.
- Per-cycle priority, evaluated on the pre-edge state:
  1. iPush and iPop in the same cycle: stack no-op, no error bits set. Flags follow upd.
  2. iPop only, stack not empty: flags load the top entry and count decrements. upd is ignored this cycle because the restore wins.
  3. iPop only, stack empty: oStackUnderflow is set. The flags, count and stack contents are unchanged. Flags follow upd.
  4. iPush only, stack not full: the pre-edge flags are written at index count and count increments. Flags follow upd in the same cycle.
  5. iPush only, stack full: oStackOverflow is set. Nothing is written and count is unchanged. Flags follow upd.
  6. Neither: flags follow upd and hold otherwise.
- iClearErr clears both sticky bits. If a new error occurs in the same cycle, the set wins.
- Reset values:
  - all flags 0
  - oStackCount 0
  - both error bits 0
  - stack contents don't-care, never observable before a write

## Timing
- Latency is 1 cycle. Flags computed in cycle n appear on the outputs in cycle n+1, and a branch in cycle n+1 sees them.
- No combinational path from any input to any output. Every output is a flop.
- Back-to-back updates are supported every cycle. The last committed update wins.
- Asserting iRst_n low mid-sequence clears the flags, count and errors immediately, without waiting for a clock edge. In-flight push or pop is lost.
- Count wrap-around cannot occur because full and empty are guarded. Count stays in the range 0..STACK_DEPTH.

## Structure
- Shared package cpu_flags_pkg holds:
  - the iAluOp encodings FLAG_ADD, FLAG_SUB, FLAG_LOGIC, FLAG_NOFLAG
  - a flags_t struct {z, n, v}
- Sub-module flag_stack: a parameterised LIFO that owns the storage, the count, and the full/empty and error generation. The top level holds the flag compute, the priority mux and the flag registers.

## Test plan
- Reset: drive iRst_n low mid-operation → all flags 0, oStackCount 0, error bits 0 without waiting for a clock edge.
- ADD with DATA_WIDTH=16, A=0x7FFF, B=0x0001, R=0x8000 → next cycle Z=0, N=1, V=1. SUB with A=0x0005, B=0x0005, R=0x0000 → Z=1, N=0, V=0.
- LOGIC with R=0x0000 following a V=1 state → Z=1, V=0. NOFLAG, or a flushed ADD, with R=0 → flags unchanged.
- Push with flags {1,0,1} and an ADD with R=0x0001 in the same cycle → flags become {0,0,0} and count becomes 1. A later pop with a simultaneous ALU update → flags restored to {1,0,1} and count 0.
- Five pushes at STACK_DEPTH=4 → count saturates at 4 and oStackOverflow is set on the fifth. Pop on an empty stack → oStackUnderflow set and flags held. iClearErr → both error bits cleared.
- iPush and iPop together on a count-2 stack → count stays 2, contents unchanged, no error bits set.
